// File: rtl/regfile_read_port.sv
// Paired-read port for a 32-entry register file with a 2-deep registered response queue.
// Optional macro RF_BYPASS_EN forwards the same-edge write data (D) into captured reads.
module regfile_read_port #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic               Clk,
  input  logic               Clrn,
  input  logic [NREG*DW-1:0] Q_all,
  input  logic               Wen,
  input  logic [4:0]         Wn,
  input  logic [DW-1:0]      D,
  input  logic               Req_valid,
  output logic               Req_ready,
  input  logic [4:0]         Ra,
  input  logic [4:0]         Rb,
  output logic               Rsp_valid,
  input  logic               Rsp_ready,
  output logic [DW-1:0]      Qa,
  output logic [DW-1:0]      Qb,
  output logic [1:0]         Count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state_r, state_n_s;
  logic [DW-1:0] head_a_r, head_b_r, tail_a_r, tail_b_r;
  logic [DW-1:0] head_a_n_s, head_b_n_s, tail_a_n_s, tail_b_n_s;
  logic [DW-1:0] rd_a_s, rd_b_s, new_a_s, new_b_s;
  logic          accept_s, pop_s;
  logic          unused_s;

  // Register 0 and addresses at or above NREG fall through to zero.
  function automatic logic [DW-1:0] read_sel(input logic [4:0] addr,
                                             input logic [NREG*DW-1:0] q);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 1; i < NREG; i++) begin
      r = (addr == 5'(i)) ? q[i*DW +: DW] : r;
    end
    return r;
  endfunction

  assign rd_a_s = read_sel(Ra, Q_all);
  assign rd_b_s = read_sel(Rb, Q_all);

`ifdef RF_BYPASS_EN
  assign new_a_s  = (Wen && (Wn != 5'd0) && (Wn == Ra)) ? D : rd_a_s;
  assign new_b_s  = (Wen && (Wn != 5'd0) && (Wn == Rb)) ? D : rd_b_s;
  assign unused_s = ^Q_all[DW-1:0];
`else
  assign new_a_s  = rd_a_s;
  assign new_b_s  = rd_b_s;
  assign unused_s = ^{Q_all[DW-1:0], Wen, Wn, D};
`endif

  // Handshake decodes come only from the state register.
  assign Req_ready = (state_r != TWO);
  assign Rsp_valid = (state_r != EMPTY);
  assign Count     = state_r;
  assign Qa        = head_a_r;
  assign Qb        = head_b_r;
  assign accept_s  = Req_valid & Req_ready;
  assign pop_s     = Rsp_valid & Rsp_ready;

  // Queue next-state: head/tail movement per accept/pop combination.
  always_comb begin
    state_n_s  = state_r;
    head_a_n_s = head_a_r;
    head_b_n_s = head_b_r;
    tail_a_n_s = tail_a_r;
    tail_b_n_s = tail_b_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_n_s  = ONE;
          head_a_n_s = new_a_s;
          head_b_n_s = new_b_s;
        end else begin
          state_n_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && pop_s) begin
          head_a_n_s = new_a_s;
          head_b_n_s = new_b_s;
        end else if (accept_s) begin
          state_n_s  = TWO;
          tail_a_n_s = new_a_s;
          tail_b_n_s = new_b_s;
        end else if (pop_s) begin
          state_n_s = EMPTY;
        end else begin
          state_n_s = ONE;
        end
      end
      TWO: begin
        if (pop_s) begin
          state_n_s  = ONE;
          head_a_n_s = tail_a_r;
          head_b_n_s = tail_b_r;
        end else begin
          state_n_s = TWO;
        end
      end
      default: begin
        state_n_s = EMPTY;
      end
    endcase
  end

  // State and entry registers; reset discards all buffered entries.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_r  <= EMPTY;
      head_a_r <= '0;
      head_b_r <= '0;
      tail_a_r <= '0;
      tail_b_r <= '0;
    end else begin
      state_r  <= state_n_s;
      head_a_r <= head_a_n_s;
      head_b_r <= head_b_n_s;
      tail_a_r <= tail_a_n_s;
      tail_b_r <= tail_b_n_s;
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: vector table of single reads plus
// backpressure, accept+pop and asynchronous-reset sequences.
module tb_regfile_read_port;

  localparam int DW   = 32;
  localparam int NREG = 32;

  logic               Clk;
  logic               Clrn;
  logic [NREG*DW-1:0] Q_all;
  logic               Wen;
  logic [4:0]         Wn;
  logic [DW-1:0]      D;
  logic               Req_valid;
  logic               Req_ready;
  logic [4:0]         Ra;
  logic [4:0]         Rb;
  logic               Rsp_valid;
  logic               Rsp_ready;
  logic [DW-1:0]      Qa;
  logic [DW-1:0]      Qb;
  logic [1:0]         Count;

  int n_total;
  int n_pass;

  regfile_read_port #(.DW(DW), .NREG(NREG)) dut (
    .Clk(Clk), .Clrn(Clrn), .Q_all(Q_all), .Wen(Wen), .Wn(Wn), .D(D),
    .Req_valid(Req_valid), .Req_ready(Req_ready), .Ra(Ra), .Rb(Rb),
    .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready), .Qa(Qa), .Qb(Qb),
    .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        wen;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_reg(input int idx, input logic [31:0] val);
    Q_all[idx*DW +: DW] = val;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, Rsp_valid}, 32'd0);
    check({tag, "_count"},     {30'd0, Count},     32'd0);
    check({tag, "_req_ready"}, {31'd0, Req_ready}, 32'd1);
    check({tag, "_qa"},        Qa,                 32'd0);
    check({tag, "_qb"},        Qb,                 32'd0);
  endtask

  // One request into an empty queue, held one cycle, then popped.
  task automatic single_read(input vec_t v);
    @(negedge Clk);
    Req_valid = 1'b1; Ra = v.ra; Rb = v.rb; Wen = v.wen; Wn = v.wn; D = v.d;
    Rsp_ready = 1'b0;
    @(negedge Clk);
    Req_valid = 1'b0; Wen = 1'b0;
    check({v.name, "_rsp_valid"}, {31'd0, Rsp_valid}, 32'd1);
    check({v.name, "_count"},     {30'd0, Count},     32'd1);
    check({v.name, "_qa"},        Qa,                 v.exp_a);
    check({v.name, "_qb"},        Qb,                 v.exp_b);
    Rsp_ready = 1'b1;
    @(negedge Clk);
    check({v.name, "_drain"}, {30'd0, Count}, 32'd0);
    Rsp_ready = 1'b0;
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    Clrn = 1'b0; Q_all = '0; Wen = 1'b0; Wn = 5'd0; D = 32'd0;
    Req_valid = 1'b0; Ra = 5'd0; Rb = 5'd0; Rsp_ready = 1'b0;
    set_reg(0,  32'hFFFF_FFFF);
    set_reg(1,  32'h1111_1111);
    set_reg(2,  32'h2222_2222);
    set_reg(3,  32'h3333_3333);
    set_reg(5,  32'h1234_5678);
    set_reg(7,  32'hAAAA_0000);
    set_reg(9,  32'hCAFE_F00D);
    set_reg(31, 32'h3131_3131);

    vecs[0] = '{"rd5_9",   5'd5,  5'd9, 1'b0, 5'd0, 32'd0, 32'h1234_5678, 32'hCAFE_F00D};
    vecs[1] = '{"reg0",    5'd0,  5'd0, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0};
`ifdef RF_BYPASS_EN
    vecs[2] = '{"byp7",    5'd7,  5'd7, 1'b1, 5'd7, 32'h5555_FFFF, 32'h5555_FFFF, 32'h5555_FFFF};
    vecs[4] = '{"byp_b",   5'd7,  5'd9, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'hAAAA_0000, 32'hDEAD_BEEF};
`else
    vecs[2] = '{"byp7",    5'd7,  5'd7, 1'b1, 5'd7, 32'h5555_FFFF, 32'hAAAA_0000, 32'hAAAA_0000};
    vecs[4] = '{"byp_b",   5'd7,  5'd9, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'hAAAA_0000, 32'hCAFE_F00D};
`endif
    vecs[3] = '{"wn0",     5'd7,  5'd0, 1'b1, 5'd0, 32'h5555_FFFF, 32'hAAAA_0000, 32'h0};
    vecs[5] = '{"rd31_1",  5'd31, 5'd1, 1'b0, 5'd0, 32'd0, 32'h3131_3131, 32'h1111_1111};

    @(negedge Clk);
    @(negedge Clk);
    check_idle("reset");
    Clrn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      single_read(vecs[i]);
    end

    // Backpressure: fill to two, stall, then drain with a concurrent accept.
    @(negedge Clk);
    Rsp_ready = 1'b0; Req_valid = 1'b1; Ra = 5'd1; Rb = 5'd1;
    @(negedge Clk);
    check("bp_count1", {30'd0, Count}, 32'd1);
    check("bp_ready1", {31'd0, Req_ready}, 32'd1);
    Ra = 5'd2; Rb = 5'd2;
    @(negedge Clk);
    check("bp_count2", {30'd0, Count}, 32'd2);
    check("bp_ready2", {31'd0, Req_ready}, 32'd0);
    check("bp_head1", Qa, 32'h1111_1111);
    Ra = 5'd3; Rb = 5'd3;
    set_reg(1, 32'h0BAD_BAD0);
    @(negedge Clk);
    check("bp_stall_count", {30'd0, Count}, 32'd2);
    check("bp_stall_qa", Qa, 32'h1111_1111);
    check("bp_stall_qb", Qb, 32'h1111_1111);
    Rsp_ready = 1'b1;
    @(negedge Clk);
    check("bp_pop_count", {30'd0, Count}, 32'd1);
    check("bp_head2", Qa, 32'h2222_2222);
    check("bp_ready3", {31'd0, Req_ready}, 32'd1);
    @(negedge Clk);
    Req_valid = 1'b0;
    check("accpop_count", {30'd0, Count}, 32'd1);
    check("accpop_qa", Qa, 32'h3333_3333);
    check("accpop_qb", Qb, 32'h3333_3333);
    @(negedge Clk);
    check("bp_drain", {30'd0, Count}, 32'd0);
    Rsp_ready = 1'b0;
    set_reg(1, 32'h1111_1111);

    // Asynchronous reset between edges with two entries buffered.
    Req_valid = 1'b1; Ra = 5'd5; Rb = 5'd9;
    @(negedge Clk);
    @(negedge Clk);
    Req_valid = 1'b0;
    check("pre_rst_count", {30'd0, Count}, 32'd2);
    #2 Clrn = 1'b0;
    #1 check_idle("midrst");
    #1 Clrn = 1'b1;
    single_read('{"post_rst", 5'd9, 5'd5, 1'b0, 5'd0, 32'd0, 32'hCAFE_F00D, 32'h1234_5678});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
